// File: rtl/ladybird_config_pkg.sv
// ladybird_config: shared bus widths and responder state encoding for the ladybird request/grant bus
package ladybird_config;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int STRB_W = 4;
   typedef enum logic [1:0] {IDLE, WAIT, READ, RESP} responder_state_t;
endpackage

// File: rtl/ladybird_byte_ram.sv
// ladybird_byte_ram: single-port DEPTH x 32 RAM with per-byte write enables and a one-cycle registered read
// Ports:
//   clk   - clock
//   we    - per-byte write enables (bit i writes wdata[8i+7:8i])
//   re    - read enable; rdata holds its value when low
//   idx   - word index
//   wdata - write data
//   rdata - registered read data, valid the cycle after re
module ladybird_byte_ram
   import ladybird_config::*;
#(
   parameter int DEPTH = 1024
) (
   input  logic                     clk,
   input  logic [STRB_W-1:0]        we,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] idx,
   input  logic [DATA_W-1:0]        wdata,
   output logic [DATA_W-1:0]        rdata
);
   logic [DATA_W-1:0] mem [DEPTH];
   always_ff @(posedge clk) begin
      for (int i = 0; i < STRB_W; i++)
         if (we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      if (re) rdata <= mem[idx];
   end
endmodule

// File: rtl/ladybird_bus_responder.sv
// ladybird_bus_responder: secondary-side ladybird bus endpoint backed by a byte-writable local RAM
// Ports:
//   clk       - clock
//   anrst     - asynchronous active-low reset
//   req       - request from the primary
//   addr      - byte address; bits [1:0] are ignored
//   wstrb     - byte strobes; nonzero means store, zero means load
//   data      - shared data bus; driven here only while data_gnt is high
//   gnt       - grant, combinational on the accept cycle
//   data_gnt  - one-cycle load response strobe
//   err_pulse - one-cycle pulse on an accepted access beyond DEPTH words
module ladybird_bus_responder
   import ladybird_config::*;
#(
   parameter int DEPTH        = 1024,
   parameter int WAIT_STATES  = 0,
   parameter int READ_LATENCY = 2
) (
   input  logic              clk,
   input  logic              anrst,
   input  logic              req,
   input  logic [ADDR_W-1:0] addr,
   input  logic [STRB_W-1:0] wstrb,
   inout  wire  [DATA_W-1:0] data,
   output logic              gnt,
   output logic              data_gnt,
   output logic              err_pulse
);
   localparam int AW = $clog2(DEPTH);
   localparam int WW = WAIT_STATES > 0 ? $clog2(WAIT_STATES + 1) : 1;
   responder_state_t  state;
   logic [WW-1:0]     wcnt;
   logic [3:0]        lcnt;
   logic              oor_q;
   logic              store;
   logic              oor;
   logic [DATA_W-1:0] rdata;
   logic              unused;
   assign unused = ^addr[1:0];
   assign store  = |wstrb;
   assign oor    = addr[ADDR_W-1:2] >= (ADDR_W - 2)'(DEPTH);
   // Grant is held off while reset is asserted so nothing is accepted mid-reset
   assign gnt       = anrst && req && ((state == IDLE && WAIT_STATES == 0) ||
                                       (state == WAIT && wcnt == WW'(WAIT_STATES)));
   assign err_pulse = gnt && oor;
   assign data_gnt  = state == RESP;
   // Out-of-range loads still complete, but return zero instead of aliased RAM data
   assign data      = data_gnt ? (oor_q ? '0 : rdata) : 'z;
   ladybird_byte_ram #(.DEPTH(DEPTH)) u_ram (
      .clk   (clk),
      .we    (gnt && store && !oor ? wstrb : '0),
      .re    (gnt && !store),
      .idx   (addr[AW+1:2]),
      .wdata (data),
      .rdata (rdata)
   );
   always_ff @(posedge clk or negedge anrst) begin
      if (!anrst) begin
         state <= IDLE;
         wcnt  <= '0;
         lcnt  <= '0;
         oor_q <= 1'b0;
      end else if (gnt) begin
         // Stores complete on acceptance; loads wait out the read latency
         state <= store ? IDLE : (READ_LATENCY == 1 ? RESP : READ);
         lcnt  <= 4'd1;
         if (!store) oor_q <= oor;
      end else begin
         case (state)
            IDLE: if (req && WAIT_STATES > 0) begin
               state <= WAIT;
               wcnt  <= WW'(1);
            end
            WAIT: if (!req) state <= IDLE;
                  else wcnt <= wcnt + 1'b1;
            READ: begin
               lcnt <= lcnt + 4'd1;
               if (lcnt + 4'd1 == 4'(READ_LATENCY)) state <= RESP;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ladybird_bus_responder.sv
// tb_ladybird_bus_responder: directed and randomized checks of two responder configurations against a word-array model
module tb_ladybird_bus_responder;
   logic        clk = 1'b0;
   logic        anrst = 1'b0;
   logic [1:0]  req = '0;
   logic [31:0] addr [2];
   logic [3:0]  wstrb [2];
   logic [31:0] drv [2];
   logic [1:0]  den = 2'b11;
   wire  [31:0] data0, data1;
   wire  [1:0]  gnt, dg, err;
   int          passed = 0;
   int          total = 0;
   logic [31:0] mem [2][1024];

   // The primary parks the bus at zero whenever it is not expecting a response
   assign data0 = den[0] ? drv[0] : 'z;
   assign data1 = den[1] ? drv[1] : 'z;

   always #5 clk = ~clk;

   ladybird_bus_responder #(.DEPTH(1024), .WAIT_STATES(0), .READ_LATENCY(2)) dut0 (
      .clk(clk), .anrst(anrst), .req(req[0]), .addr(addr[0]), .wstrb(wstrb[0]),
      .data(data0), .gnt(gnt[0]), .data_gnt(dg[0]), .err_pulse(err[0]));
   ladybird_bus_responder #(.DEPTH(1024), .WAIT_STATES(3), .READ_LATENCY(3)) dut1 (
      .clk(clk), .anrst(anrst), .req(req[1]), .addr(addr[1]), .wstrb(wstrb[1]),
      .data(data1), .gnt(gnt[1]), .data_gnt(dg[1]), .err_pulse(err[1]));

   function automatic logic [31:0] bus(input int u);
      return u != 0 ? data1 : data0;
   endfunction
   function automatic int ws_of(input int u);
      return u != 0 ? 3 : 0;
   endfunction
   function automatic int rl_of(input int u);
      return u != 0 ? 3 : 2;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Called at posedge+1 with req already raised; n = cycles before grant, -1 on timeout
   task automatic wait_gnt(input int u, output int n);
      n = 0;
      forever begin
         @(negedge clk);
         if (gnt[u]) break;
         n++;
         if (n > 20) begin
            n = -1;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic store(input int u, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      int   n;
      logic oor;
      oor = a[31:2] >= 30'd1024;
      req[u] = 1'b1; addr[u] = a; wstrb[u] = s; drv[u] = d;
      wait_gnt(u, n);
      chk("store_wait", 32'(n), 32'(ws_of(u)));
      chk("store_err", 32'(err[u]), 32'(oor));
      @(posedge clk); #1;
      req[u] = 1'b0; wstrb[u] = '0; drv[u] = '0;
      if (!oor)
         for (int b = 0; b < 4; b++)
            if (s[b]) mem[u][a[11:2]][8*b +: 8] = d[8*b +: 8];
   endtask

   task automatic load(input int u, input logic [31:0] a);
      int          n;
      logic        oor;
      logic [31:0] exp;
      oor = a[31:2] >= 30'd1024;
      exp = oor ? 32'h0 : mem[u][a[11:2]];
      req[u] = 1'b1; addr[u] = a; wstrb[u] = '0;
      wait_gnt(u, n);
      chk("load_wait", 32'(n), 32'(ws_of(u)));
      chk("load_err", 32'(err[u]), 32'(oor));
      @(posedge clk); #1;
      req[u] = 1'b0;
      for (int i = 1; i <= rl_of(u); i++) begin
         if (i == rl_of(u)) den[u] = 1'b0;
         @(negedge clk);
         chk("load_dgnt", 32'(dg[u]), 32'(i == rl_of(u)));
         chk("load_data", bus(u), i == rl_of(u) ? exp : 32'h0);
         @(posedge clk); #1;
         den[u] = 1'b1;
      end
      @(negedge clk);
      chk("load_done", 32'(dg[u]), 32'h0);
      chk("load_park", bus(u), 32'h0);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [29:0] w;
      logic [31:0] a;
      int          u;
      for (int k = 0; k < 2; k++) begin
         addr[k] = '0; wstrb[k] = '0; drv[k] = '0;
      end
      req = 2'b11;
      repeat (2) @(negedge clk);
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_dgnt", 32'(dg), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      req = 2'b00;
      @(posedge clk); #1;
      anrst = 1'b1;

      store(0, 32'h10, 32'hDEADBEEF, 4'hF);
      load(0, 32'h10);

      store(0, 32'h20, 32'h11223344, 4'hF);
      store(0, 32'h20, 32'hAABBCCDD, 4'b0101);
      load(0, 32'h20);
      chk("partial_model", mem[0][8], 32'h11BB33DD);

      store(0, 32'h30, 32'h01020304, 4'hF);
      store(0, 32'h34, 32'h05060708, 4'hF);
      req[0] = 1'b1; addr[0] = 32'h30; wstrb[0] = '0;
      @(negedge clk);
      chk("oo_gnt_a", 32'(gnt[0]), 32'h1);
      @(posedge clk); #1;
      addr[0] = 32'h34;
      @(negedge clk);
      chk("oo_gnt_read", 32'(gnt[0]), 32'h0);
      chk("oo_dg_read", 32'(dg[0]), 32'h0);
      @(posedge clk); #1;
      den[0] = 1'b0;
      @(negedge clk);
      chk("oo_gnt_resp", 32'(gnt[0]), 32'h0);
      chk("oo_dg_a", 32'(dg[0]), 32'h1);
      chk("oo_data_a", data0, 32'h01020304);
      @(posedge clk); #1;
      den[0] = 1'b1;
      @(negedge clk);
      chk("oo_gnt_b", 32'(gnt[0]), 32'h1);
      chk("oo_dg_idle", 32'(dg[0]), 32'h0);
      @(posedge clk); #1;
      req[0] = 1'b0;
      @(negedge clk);
      chk("oo_dg_b_read", 32'(dg[0]), 32'h0);
      @(posedge clk); #1;
      den[0] = 1'b0;
      @(negedge clk);
      chk("oo_dg_b", 32'(dg[0]), 32'h1);
      chk("oo_data_b", data0, 32'h05060708);
      @(posedge clk); #1;
      den[0] = 1'b1;

      store(0, 32'h0, 32'h0BADC0DE, 4'hF);
      load(0, 32'h0000_1000);
      store(0, 32'h0000_1000, 32'hCAFEF00D, 4'hF);
      load(0, 32'h0);

      store(1, 32'h40, 32'h12345678, 4'hF);
      req[1] = 1'b1; addr[1] = 32'h40; wstrb[1] = 4'hF; drv[1] = 32'hFFFFFFFF;
      @(negedge clk);
      chk("drop_gnt0", 32'(gnt[1]), 32'h0);
      @(posedge clk); #1;
      req[1] = 1'b0; wstrb[1] = '0; drv[1] = '0;
      @(negedge clk);
      chk("drop_gnt1", 32'(gnt[1]), 32'h0);
      @(posedge clk); #1;
      load(1, 32'h40);

      store(0, 32'h50, 32'h55AA55AA, 4'hF);
      req[0] = 1'b1; addr[0] = 32'h50; wstrb[0] = '0;
      @(negedge clk);
      chk("rst_accept", 32'(gnt[0]), 32'h1);
      @(posedge clk); #3;
      anrst = 1'b0;
      #1;
      chk("midrst_gnt", 32'(gnt[0]), 32'h0);
      chk("midrst_dgnt", 32'(dg[0]), 32'h0);
      req[0] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      anrst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("postrst_dgnt", 32'(dg[0]), 32'h0);
         @(posedge clk); #1;
      end
      load(0, 32'h50);
      load(0, 32'h10);

      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 16; i++)
            store(k, 32'(i * 4), $urandom, 4'hF);
      for (int k = 0; k < 60; k++) begin
         u = int'($urandom_range(1, 0));
         w = $urandom_range(9, 0) == 0 ? 30'(1024 + $urandom_range(15, 0)) : 30'($urandom_range(15, 0));
         a = {w, 2'($urandom_range(3, 0))};
         if ($urandom_range(1, 0) == 1) store(u, a, $urandom, 4'($urandom_range(15, 1)));
         else load(u, a);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
